// File: rtl/spi_dual_master_arbiter.sv
// Two-requester SPI bus arbiter with mode-0 byte engine and chip-select sequencing.
// Requester A is the Z80 port interface, requester B the boot/DMA loader.
//
// state | meaning
// IDLE  | bus free, CS high, arbitrating between pending requesters
// SETUP | CS low, SCLK low for one half-period before the first edge
// SHIFT | 16 SCLK half-periods, MISO sampled on rise, MOSI updated on fall
// DONE  | one-cycle completion, rx byte and done pulse presented
// HOLD  | CS held low for the owner between bytes of a locked transaction
module spi_dual_master_arbiter #(
    parameter int CLKDIV = 2
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       a_start,
    input  logic       a_dev,
    input  logic       a_keep,
    input  logic       a_rel,
    input  logic [7:0] a_tx,
    output logic [7:0] a_rx,
    output logic       a_done,
    output logic       a_busy,
    input  logic       b_start,
    input  logic       b_dev,
    input  logic       b_keep,
    input  logic       b_rel,
    input  logic [7:0] b_tx,
    output logic [7:0] b_rx,
    output logic       b_done,
    output logic       b_busy,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       flash_cs_n,
    output logic       sd_cs_n,
    output logic       spi_active
);

    localparam logic [7:0] DIV_LOAD = 8'(CLKDIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       pend_a;
    logic       pend_b;
    logic       a_dev_h;
    logic       a_keep_h;
    logic [7:0] a_tx_h;
    logic       b_dev_h;
    logic       b_keep_h;
    logic [7:0] b_tx_h;

    logic       owner;
    logic       last_grant;
    logic       cur_keep;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [7:0] div_cnt;
    logic [3:0] half_cnt;

    logic       div_zero;
    logic       grant;
    logic       grant_sel;
    logic       release_bus;
    logic       byte_end;
    logic       owner_pend;
    logic       owner_start;
    logic       owner_rel;
    logic       sel_dev;
    logic       sel_keep;
    logic [7:0] sel_tx;
    logic       in_flight;

    assign div_zero    = (div_cnt == 8'd0);
    assign owner_pend  = owner ? pend_b  : pend_a;
    assign owner_start = owner ? b_start : a_start;
    assign owner_rel   = owner ? b_rel   : a_rel;
    assign sel_dev     = grant_sel ? b_dev_h  : a_dev_h;
    assign sel_keep    = grant_sel ? b_keep_h : a_keep_h;
    assign sel_tx      = grant_sel ? b_tx_h   : a_tx_h;

    assign in_flight   = (state != IDLE) && (state != HOLD);
    assign a_busy      = pend_a | (in_flight & ~owner);
    assign b_busy      = pend_b | (in_flight & owner);
    assign spi_active  = ~flash_cs_n | ~sd_cs_n;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        grant_sel   = 1'b0;
        release_bus = 1'b0;
        byte_end    = 1'b0;
        case (state)
            IDLE: begin
                // last_grant=1 means B was served last, so A wins a tie
                if (pend_a && (!pend_b || last_grant)) begin
                    grant     = 1'b1;
                    grant_sel = 1'b0;
                    state_nxt = SETUP;
                end else if (pend_b) begin
                    grant     = 1'b1;
                    grant_sel = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (div_zero) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (div_zero && (half_cnt == 4'd0)) begin
                    byte_end  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (cur_keep) begin
                    state_nxt = HOLD;
                end else begin
                    release_bus = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            HOLD: begin
                // A start pulse in the same cycle as a release keeps the bus
                if (owner_pend) begin
                    grant     = 1'b1;
                    grant_sel = owner;
                    state_nxt = SETUP;
                end else if (owner_rel && !owner_start) begin
                    release_bus = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a   <= 1'b0;
            a_dev_h  <= 1'b0;
            a_keep_h <= 1'b0;
            a_tx_h   <= 8'h00;
            pend_b   <= 1'b0;
            b_dev_h  <= 1'b0;
            b_keep_h <= 1'b0;
            b_tx_h   <= 8'h00;
        end else begin
            if (a_start) begin
                pend_a   <= 1'b1;
                a_dev_h  <= a_dev;
                a_keep_h <= a_keep;
                a_tx_h   <= a_tx;
            end else if (grant && !grant_sel) begin
                pend_a <= 1'b0;
            end
            if (b_start) begin
                pend_b   <= 1'b1;
                b_dev_h  <= b_dev;
                b_keep_h <= b_keep;
                b_tx_h   <= b_tx;
            end else if (grant && grant_sel) begin
                pend_b <= 1'b0;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cur_keep   <= 1'b0;
            tx_sh      <= 8'hFF;
            rx_sh      <= 8'hFF;
            div_cnt    <= 8'd0;
            half_cnt   <= 4'd0;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b1;
            flash_cs_n <= 1'b1;
            sd_cs_n    <= 1'b1;
        end else begin
            if (grant) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                cur_keep   <= sel_keep;
                spi_mosi   <= sel_tx[7];
                tx_sh      <= {sel_tx[6:0], 1'b1};
                div_cnt    <= DIV_LOAD;
                spi_clk    <= 1'b0;
                // from HOLD the held device stays selected regardless of sel_dev
                if (state == IDLE) begin
                    flash_cs_n <= sel_dev;
                    sd_cs_n    <= ~sel_dev;
                end
            end
            case (state)
                SETUP: begin
                    if (div_zero) begin
                        div_cnt  <= DIV_LOAD;
                        half_cnt <= 4'd15;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_zero) begin
                        div_cnt  <= DIV_LOAD;
                        spi_clk  <= ~spi_clk;
                        half_cnt <= half_cnt - 4'd1;
                        if (!spi_clk) begin
                            rx_sh <= {rx_sh[6:0], spi_miso};
                        end else if (half_cnt != 4'd0) begin
                            spi_mosi <= tx_sh[7];
                            tx_sh    <= {tx_sh[6:0], 1'b1};
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                DONE: begin
                    spi_mosi <= 1'b1;
                end
                default: begin
                end
            endcase
            if (release_bus) begin
                flash_cs_n <= 1'b1;
                sd_cs_n    <= 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            a_rx   <= 8'hFF;
            b_rx   <= 8'hFF;
            a_done <= 1'b0;
            b_done <= 1'b0;
        end else begin
            a_done <= byte_end & ~owner;
            b_done <= byte_end & owner;
            if (byte_end && !owner) begin
                a_rx <= rx_sh;
            end
            if (byte_end && owner) begin
                b_rx <= rx_sh;
            end
        end
    end

endmodule

// File: tb/tb_spi_dual_master_arbiter.sv
// Bench for spi_dual_master_arbiter: SPI slave model, transaction scoreboard,
// directed corner sequences, a vector table and randomized arbitration rounds.
module tb_spi_dual_master_arbiter;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       a_start = 1'b0, a_dev = 1'b0, a_keep = 1'b0, a_rel = 1'b0;
    logic [7:0] a_tx = 8'h00;
    logic [7:0] a_rx;
    logic       a_done, a_busy;
    logic       b_start = 1'b0, b_dev = 1'b0, b_keep = 1'b0, b_rel = 1'b0;
    logic [7:0] b_tx = 8'h00;
    logic [7:0] b_rx;
    logic       b_done, b_busy;
    logic       spi_clk, spi_mosi, spi_miso, flash_cs_n, sd_cs_n, spi_active;

    spi_dual_master_arbiter #(.CLKDIV(2)) dut (
        .sysclk(sysclk), .rst_n(rst_n),
        .a_start(a_start), .a_dev(a_dev), .a_keep(a_keep), .a_rel(a_rel), .a_tx(a_tx),
        .a_rx(a_rx), .a_done(a_done), .a_busy(a_busy),
        .b_start(b_start), .b_dev(b_dev), .b_keep(b_keep), .b_rel(b_rel), .b_tx(b_tx),
        .b_rx(b_rx), .b_done(b_done), .b_busy(b_busy),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .flash_cs_n(flash_cs_n), .sd_cs_n(sd_cs_n), .spi_active(spi_active)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // SPI slave: presents tab[sidx] MSB first, shifts on SCLK fall, records MOSI on rise
    logic [7:0]  tab [256];
    logic [7:0]  sidx = 8'd0;
    logic [2:0]  fbit = 3'd7;
    int          rcnt = 0;
    logic [7:0]  cap = 8'h00;
    logic [15:0] got_q [$];

    assign spi_miso = tab[sidx][fbit];

    always @(posedge spi_clk) begin
        if (rst_n === 1'b1) begin
            cap  = {cap[6:0], spi_mosi};
            rcnt = rcnt + 1;
        end
    end

    always @(negedge spi_clk) begin
        if (rst_n === 1'b1) begin
            if (rcnt == 8) begin
                got_q.push_back({cap, tab[sidx]});
                sidx = sidx + 8'd1;
                rcnt = 0;
                fbit = 3'd7;
            end else begin
                fbit = fbit - 3'd1;
            end
        end
    end

    always @(negedge rst_n) begin
        rcnt = 0;
        fbit = 3'd7;
        sidx = sidx + 8'd1;
        got_q.delete();
    end

    typedef struct packed {
        logic       who;
        logic       dev;
        logic [7:0] tx;
    } exp_t;

    exp_t exp_q [$];
    logic m_last = 1'b1;
    int   done_cnt = 0;
    logic cs_both = 1'b0;
    logic saw_flash = 1'b0, saw_sd = 1'b0;
    logic watch_en = 1'b0, watch_dev = 1'b0, watch_bbusy = 1'b0, watch_bad = 1'b0;

    task automatic check_done();
        exp_t        e;
        logic [15:0] g;
        logic        who;
        who = b_done;
        chk("done_single", {31'd0, a_done & b_done}, 0);
        if (exp_q.size() == 0) begin
            chk("done_expected", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("done_who", {31'd0, who}, {31'd0, e.who});
            chk("done_cs", {30'd0, flash_cs_n, sd_cs_n}, e.dev ? 2'b10 : 2'b01);
            if (got_q.size() == 0) begin
                chk("done_byte_seen", 0, 1);
            end else begin
                g = got_q.pop_front();
                chk("done_mosi", {24'd0, g[15:8]}, {24'd0, e.tx});
                chk("done_rx", {24'd0, who ? b_rx : a_rx}, {24'd0, g[7:0]});
            end
        end
    endtask

    always @(negedge sysclk) begin
        if (rst_n === 1'b1) begin
            if (!flash_cs_n && !sd_cs_n) cs_both = 1'b1;
            if (!flash_cs_n) saw_flash = 1'b1;
            if (!sd_cs_n) saw_sd = 1'b1;
            if (watch_en) begin
                if (watch_dev ? (sd_cs_n !== 1'b0 || flash_cs_n !== 1'b1)
                              : (flash_cs_n !== 1'b0 || sd_cs_n !== 1'b1)) watch_bad = 1'b1;
                if (watch_bbusy && b_busy !== 1'b1) watch_bad = 1'b1;
            end
            if (a_done === 1'b1 || b_done === 1'b1) begin
                done_cnt++;
                check_done();
            end
        end
    end

    typedef struct packed {
        logic       start;
        logic       dev;
        logic       keep;
        logic       rel;
        logic [7:0] tx;
    } req_t;

    localparam req_t NOREQ = '0;

    function automatic req_t rq(input logic dev, input logic keep, input logic [7:0] tx);
        req_t r;
        r = NOREQ;
        r.start = 1'b1;
        r.dev = dev;
        r.keep = keep;
        r.tx = tx;
        return r;
    endfunction

    function automatic req_t rl();
        req_t r;
        r = NOREQ;
        r.rel = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic pulse(input req_t ra, input req_t rb);
        a_start = ra.start; a_dev = ra.dev; a_keep = ra.keep; a_rel = ra.rel; a_tx = ra.tx;
        b_start = rb.start; b_dev = rb.dev; b_keep = rb.keep; b_rel = rb.rel; b_tx = rb.tx;
        tick();
        a_start = 1'b0; a_rel = 1'b0; b_start = 1'b0; b_rel = 1'b0;
    endtask

    task automatic pulse_one(input logic who, input req_t r);
        if (who) pulse(NOREQ, r);
        else pulse(r, NOREQ);
    endtask

    // model: every granted byte becomes an expected completion, and moves last_grant
    task automatic expect_txn(input logic who, input logic dev, input logic [7:0] tx);
        exp_t e;
        e.who = who;
        e.dev = dev;
        e.tx = tx;
        exp_q.push_back(e);
        m_last = who;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_last = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct packed {
        logic       who;
        logic       dev;
        logic [7:0] tx;
        logic [7:0] slv;
        logic [7:0] exp_rx;
        logic [1:0] exp_cs_seen;
    } vec_t;

    vec_t vt [6];

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog no_finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   n;
        logic bad;
        int   dc;
        for (int i = 0; i < 256; i++) tab[i] = 8'($urandom);
        vt[0] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 2'b10};
        vt[1] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 2'b01};
        vt[2] = '{1'b0, 1'b1, 8'h81, 8'h7E, 8'h7E, 2'b01};
        vt[3] = '{1'b1, 1'b0, 8'h5A, 8'hA5, 8'hA5, 2'b10};
        vt[4] = '{1'b0, 1'b0, 8'hC3, 8'h01, 8'h01, 2'b10};
        vt[5] = '{1'b1, 1'b1, 8'h3C, 8'h80, 8'h80, 2'b01};

        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_pins", {24'd0, spi_clk, spi_mosi, flash_cs_n, sd_cs_n, a_done, b_done, a_busy, b_busy},
            32'b0111_0000);
        chk("reset_a_rx", {24'd0, a_rx}, 32'hFF);
        chk("reset_b_rx", {24'd0, b_rx}, 32'hFF);
        rst_n = 1'b1;
        tick();

        // single flash byte: latency, CS framing, bit order
        tab[sidx] = 8'h3C;
        expect_txn(1'b0, 1'b0, 8'hA5);
        pulse(rq(1'b0, 1'b0, 8'hA5), NOREQ);
        n = 0;
        bad = 1'b0;
        while (a_done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (flash_cs_n !== 1'b0 || sd_cs_n !== 1'b1) bad = 1'b1;
        end
        chk("t1_latency", n, 35);
        chk("t1_cs_low", {31'd0, bad}, 0);
        chk("t1_mosi_bits", {24'd0, cap}, 32'hA5);
        chk("t1_rx", {24'd0, a_rx}, 32'h3C);
        tick();
        chk("t1_cs_release", {30'd0, flash_cs_n, sd_cs_n}, 2'b11);
        drain(10);

        // tie after reset goes to A; a second tie during A's byte goes to B next
        do_reset();
        dc = done_cnt;
        expect_txn(1'b0, 1'b0, 8'h11);
        pulse(rq(1'b0, 1'b0, 8'h11), rq(1'b1, 1'b0, 8'h22));
        repeat (4) tick();
        pulse(rq(1'b1, 1'b0, 8'h33), rq(1'b0, 1'b0, 8'h44));
        expect_txn(1'b1, 1'b0, 8'h44);
        expect_txn(1'b0, 1'b1, 8'h33);
        drain(400);
        chk("t2_done_count", done_cnt - dc, 3);
        repeat (2) tick();

        // locked SD burst by A with B pending; a flash-addressed byte stays on SD
        pulse(rq(1'b1, 1'b1, 8'h5A), NOREQ);
        pulse(NOREQ, rq(1'b0, 1'b0, 8'hC3));
        expect_txn(1'b0, 1'b1, 8'h5A);
        drain(200);
        watch_bad = 1'b0; watch_dev = 1'b1; watch_bbusy = 1'b1; watch_en = 1'b1;
        saw_flash = 1'b0;
        expect_txn(1'b0, 1'b1, 8'h96);
        pulse(rq(1'b0, 1'b1, 8'h96), NOREQ);
        drain(200);
        expect_txn(1'b0, 1'b1, 8'h0F);
        pulse(rq(1'b1, 1'b1, 8'h0F), NOREQ);
        drain(200);
        repeat (5) tick();
        watch_en = 1'b0;
        chk("t3_sd_held_b_waiting", {31'd0, watch_bad}, 0);
        chk("t4_flash_never", {31'd0, saw_flash}, 0);
        chk("t3_b_still_busy", {31'd0, b_busy}, 1);
        expect_txn(1'b1, 1'b0, 8'hC3);
        pulse(rl(), NOREQ);
        drain(200);
        tick();
        chk("t3_b_idle_after", {30'd0, a_busy, b_busy}, 0);

        // reset in the middle of a byte
        dc = done_cnt;
        pulse(rq(1'b0, 1'b0, 8'h77), NOREQ);
        n = 0;
        while (rcnt < 5 && n < 200) begin
            tick();
            n++;
        end
        chk("t5_rise5_reached", rcnt, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_pins", {29'd0, spi_clk, flash_cs_n, sd_cs_n}, 3'b011);
        exp_q.delete();
        m_last = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("t5_rx_reset", {24'd0, a_rx}, 32'hFF);
        chk("t5_not_busy", {31'd0, a_busy}, 0);
        repeat (50) tick();
        chk("t5_no_done", done_cnt - dc, 0);

        // foreign release ignored; own release with start keeps the bus
        expect_txn(1'b0, 1'b0, 8'hE1);
        pulse(rq(1'b0, 1'b1, 8'hE1), NOREQ);
        drain(200);
        watch_bad = 1'b0; watch_dev = 1'b0; watch_bbusy = 1'b0; watch_en = 1'b1;
        pulse(NOREQ, rl());
        repeat (3) tick();
        begin
            req_t r;
            r = rq(1'b1, 1'b0, 8'h3E);
            r.rel = 1'b1;
            expect_txn(1'b0, 1'b0, 8'h3E);
            pulse(r, NOREQ);
        end
        drain(200);
        watch_en = 1'b0;
        chk("t6_cs_held", {31'd0, watch_bad}, 0);
        chk("t6_cs_released", {30'd0, flash_cs_n, sd_cs_n}, 2'b11);
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            tab[sidx] = vt[i].slv;
            saw_flash = 1'b0;
            saw_sd = 1'b0;
            expect_txn(vt[i].who, vt[i].dev, vt[i].tx);
            pulse_one(vt[i].who, rq(vt[i].dev, 1'b0, vt[i].tx));
            drain(200);
            chk("vec_cs_used", {30'd0, saw_flash, saw_sd}, {30'd0, vt[i].exp_cs_seen});
            chk("vec_rx", {24'd0, vt[i].who ? b_rx : a_rx}, {24'd0, vt[i].exp_rx});
            repeat (2) tick();
        end

        for (int r = 0; r < 30; r++) begin
            int         kind;
            logic       x, y, ypend, dx, dy, fk;
            logic [7:0] tx_x, tx_y;
            int         nb;
            kind = $urandom_range(0, 2);
            x = 1'($urandom);
            y = ~x;
            dx = 1'($urandom);
            dy = 1'($urandom);
            tx_x = 8'($urandom);
            tx_y = 8'($urandom);
            if (kind == 0) begin
                expect_txn(x, dx, tx_x);
                pulse_one(x, rq(dx, 1'b0, tx_x));
                drain(200);
            end else if (kind == 1) begin
                if (!m_last) begin
                    expect_txn(1'b1, dy, tx_y);
                    expect_txn(1'b0, dx, tx_x);
                end else begin
                    expect_txn(1'b0, dx, tx_x);
                    expect_txn(1'b1, dy, tx_y);
                end
                pulse(rq(dx, 1'b0, tx_x), rq(dy, 1'b0, tx_y));
                drain(400);
            end else begin
                nb = $urandom_range(2, 4);
                ypend = 1'($urandom);
                fk = 1'($urandom);
                expect_txn(x, dx, tx_x);
                pulse_one(x, rq(dx, 1'b1, tx_x));
                drain(200);
                if (ypend) pulse_one(y, rq(dy, 1'b0, tx_y));
                for (int k = 1; k < nb; k++) begin
                    logic [7:0] t;
                    logic       kp;
                    t = 8'($urandom);
                    kp = (k == nb - 1) ? fk : 1'b1;
                    expect_txn(x, dx, t);
                    pulse_one(x, rq(1'($urandom), kp, t));
                    drain(200);
                    chk("rnd_other_busy", {31'd0, y ? b_busy : a_busy}, {31'd0, ypend});
                end
                if (fk) pulse_one(x, rl());
                if (ypend) begin
                    expect_txn(y, dy, tx_y);
                    drain(200);
                end
            end
            repeat (3) tick();
        end

        chk("cs_exclusive", {31'd0, cs_both}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_dual_master_arbiter.md
Name: spi_dual_master_arbiter

Overview:
- Shares the single board SPI bus (flash_cs_n, sd_cs_n, flash_clk/sd_clk, MOSI, MISO) between two requesters.
  - Requester A: the Z80 I/O-port SPI interface.
  - Requester B: the boot/DMA loader.
- Contains the byte shift engine (SPI mode 0, MSB first) and the chip-select sequencer.
- Locks the bus to one owner for multi-byte transactions, and arbitrates round-robin when both requesters are pending.
- Sits between the zxuno core's SPI users and the top-level pins; spi_active drives testled.

Parameters:
- CLKDIV, default 2: SCLK half-period in sysclk cycles. Legal range is 1..255. SCLK = sysclk/(2*CLKDIV).

Ports:
- sysclk  in  1  system clock (28 MHz nominal)
- rst_n  in  1  asynchronous, active-low reset
- a_start  in  1  one-cycle pulse: requester A issues a byte
- a_dev  in  1  target device: 0 = flash, 1 = SD
- a_keep  in  1  1 = keep CS asserted after this byte (lock bus)
- a_rel  in  1  one-cycle pulse: A releases a held bus
- a_tx  in  8  byte to send
- a_rx  out  8  last received byte for A
- a_done  out  1  one-cycle pulse: A's byte complete
- a_busy  out  1  A has a pending or in-flight byte
- b_start, b_dev, b_keep, b_rel, b_tx, b_rx, b_done, b_busy: same as the a_ ports, for requester B
- spi_clk  out  1  SCLK to flash_clk and sd_clk
- spi_mosi  out  1  MOSI to both devices
- spi_miso  in  1  MISO, already muxed by the top level
- flash_cs_n  out  1  flash chip select, active low
- sd_cs_n  out  1  SD chip select, active low
- spi_active  out  1  1 when either CS is low

Behaviour:

Reset (asynchronous, rst_n low):
- State goes to IDLE.
- spi_clk=0, spi_mosi=1, flash_cs_n=1, sd_cs_n=1.
- a_rx=b_rx=8'hFF. a_done=b_done=0.
- Pending flags cleared; owner cleared; last_grant=B (so A wins the first tie).
- A reset mid-byte aborts immediately. No done pulse is issued.

Pending flags:
- x_start sets pend_x and latches x_dev, x_keep and x_tx into per-requester holding registers.
- A start while pend_x is already set overwrites the holding registers.
- x_busy = pend_x OR (owner==x AND the state is not IDLE/HOLD).

States:
- IDLE
  - No pending flag: stay.
  - Exactly one pending: grant it.
  - Both pending: grant the requester other than last_grant.
  - On grant: load the shifter from that requester's holding registers, clear its pend flag, assert the selected CS, drive MOSI=tx[7], set last_grant, go to SETUP.
- SETUP
  - Wait CLKDIV cycles with SCLK low, then go to SHIFT.
- SHIFT
  - 16 half-periods of CLKDIV cycles each.
  - Rising SCLK edge: sample MISO into the shift register LSB.
  - Falling SCLK edge: shift out the next bit on MOSI. No MOSI update after the 8th rising edge.
  - After the 16th half-period SCLK is low; go to DONE.
- DONE (1 cycle)
  - x_rx <= received byte; x_done=1.
  - keep=1: go to HOLD with CS still low.
  - keep=0: raise CS, MOSI=1, go to IDLE.
- HOLD
  - Only the owner is served.
  - pend_owner: start a byte as in IDLE, but on the held device. The latched dev is ignored.
  - owner_rel: raise CS, go to IDLE. If the release and a start arrive in the same cycle, the start wins and the release is dropped.
  - The other requester's pend stays set until the bus returns to IDLE.
- x_rel outside HOLD, or from the non-owner: ignored.

Latency and timing:
- From the IDLE grant cycle to the done pulse: 1 + CLKDIV + 16*CLKDIV cycles. At CLKDIV=2 this is 35 cycles.
- CS deasserts in the cycle after DONE.
- Never assert both CS lines at once.

Test Plan:
1. CLKDIV=2. a_start, a_dev=0, a_keep=0, a_tx=8'hA5; MISO model returns 8'h3C → flash_cs_n low for the whole byte; MOSI bits 1,0,1,0,0,1,0,1 at rising edges; a_done 35 cycles after the grant; a_rx=8'h3C; flash_cs_n high the next cycle; sd_cs_n stays high.
2. a_start and b_start in the same cycle after reset → A served first, then B. Repeating the tie → B first, then A.
3. A sends 3 bytes to SD (dev=1), keep=1 each, with b_start pending throughout → sd_cs_n low continuously; B is not served until a_rel. Then B runs; b_busy=1 the whole time before that.
4. In HOLD, a_start with a_dev=0 → byte goes out on the SD line. flash_cs_n never asserts.
5. rst_n low at the 5th SCLK rising edge → both CS lines high, spi_clk=0 asynchronously; no a_done; a_rx=8'hFF after release.
6. b_rel while A holds the bus, plus a_rel and a_start in the same HOLD cycle → b_rel ignored; the A byte runs and CS stays low.
